// File: rtl/hex_frame_tx.sv
// UART transmitter that sends a 12-bit value as the ASCII frame 'S' + three uppercase hex digits.
// 8N1, LSB first; every bit is held CLKS_PER_BIT clocks and TX always comes straight from a flop.
module hex_frame_tx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] HEADER       = 8'h53
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        TX
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    state_t              state_q;
    logic [BAUD_W-1:0]   baudCnt_q;
    logic [2:0]          bitIdx_q;
    logic [1:0]          charIdx_q;
    logic [11:0]         data_q;
    logic                tx_q;
    logic                busy_q;
    logic                done_q;

    logic [7:0]          curChar;
    logic [2:0]          nextBitIdx;
    logic                baudWrap;

    function automatic logic [7:0] hexAscii(input logic [3:0] n);
        // 'A' - 10 = 0x37, so letters share the same offset form as digits
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        curChar = HEADER;
        case (charIdx_q)
            2'd0: curChar = HEADER;
            2'd1: curChar = hexAscii(data_q[11:8]);
            2'd2: curChar = hexAscii(data_q[7:4]);
            2'd3: curChar = hexAscii(data_q[3:0]);
            default: curChar = HEADER;
        endcase
    end

    assign nextBitIdx = bitIdx_q + 3'd1;
    assign baudWrap   = (baudCnt_q == BAUD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            charIdx_q <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baudCnt_q <= '0;
                    bitIdx_q  <= '0;
                    charIdx_q <= '0;
                    tx_q      <= 1'b1;
                    if (START) begin
                        data_q  <= DATA;
                        state_q <= START_BIT;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (baudWrap) begin
                        baudCnt_q <= '0;
                        bitIdx_q  <= '0;
                        state_q   <= DATA_BITS;
                        tx_q      <= curChar[0];
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (baudWrap) begin
                        baudCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q <= STOP_BIT;
                            tx_q    <= 1'b1;
                        end else begin
                            bitIdx_q <= nextBitIdx;
                            tx_q     <= curChar[nextBitIdx];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (baudWrap) begin
                        baudCnt_q <= '0;
                        if (charIdx_q != 2'd3) begin
                            charIdx_q <= charIdx_q + 2'd1;
                            state_q   <= START_BIT;
                            tx_q      <= 1'b0;
                        end else begin
                            // BUSY drops together with DONE so a new START is taken in the DONE cycle
                            charIdx_q <= '0;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_hex_frame_tx.sv
// Directed self-checking bench for hex_frame_tx: decodes TX with a bit-timed UART receiver
// and checks frame contents, BUSY length, DONE pulses, back-to-back framing and async reset.
module tb_hex_frame_tx;

   localparam int CPB = 104;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        START = 1'b0;
   logic [11:0] DATA = 12'h000;
   logic        BUSY;
   logic        DONE;
   logic        TX;

   int compared = 0;
   int mismatched = 0;
   int doneCount = 0;
   int busyRun = 0;
   int lastBusyRun = 0;

   hex_frame_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'h53)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .DATA  (DATA),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .TX    (TX)
   );

   // 12 MHz is not needed for behaviour; any period works since timing is in clock cycles
   always #5 CLK = ~CLK;

   // Tracks DONE pulses and the length of every contiguous BUSY run
   always @(negedge CLK) begin
      if (DONE === 1'b1) doneCount++;
      if (BUSY === 1'b1) busyRun++;
      else if (busyRun != 0) begin
         lastBusyRun = busyRun;
         busyRun = 0;
      end
   end

   // Single comparison point: counts and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Pulses START for one cycle with the given DATA, sampled on the posedge in between
   task automatic applyStimulus(input logic [11:0] value);
      @(negedge CLK);
      START = 1'b1;
      DATA  = value;
      @(negedge CLK);
      START = 1'b0;
   endtask

   // Waits for a start bit, then samples every bit near its middle
   task automatic receiveChar(output logic [7:0] c, output bit ok);
      ok = 1'b0;
      c  = 8'h00;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (TX === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         repeat (CPB / 2 - 1) @(negedge CLK);
         if (TX !== 1'b0) ok = 1'b0;
         for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge CLK);
            c[b] = TX;
         end
         repeat (CPB) @(negedge CLK);
         if (TX !== 1'b1) ok = 1'b0;
      end
   endtask

   task automatic receiveFrame(output logic [31:0] frame, output bit ok);
      logic [7:0] c;
      bit         charOk;
      ok    = 1'b1;
      frame = 32'h0;
      for (int k = 0; k < 4; k++) begin
         receiveChar(c, charOk);
         if (!charOk) ok = 1'b0;
         frame = {frame[23:0], c};
      end
   endtask

   task automatic waitDone(output bit found);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (DONE === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
   endtask

   logic [31:0] frame;
   bit          ok;
   bit          found;
   int          doneBase;
   bit          idleBad;
   logic [11:0] vecData  [4] = '{12'h259, 12'hABC, 12'hFFF, 12'h000};
   logic [31:0] vecFrame [4] = '{"S259", "SABC", "SFFF", "S000"};

   initial begin
      $display("[TB] hex_frame_tx directed test start");

      // Reset state
      repeat (3) @(negedge CLK);
      checkOutput("rst_tx", {31'h0, TX}, 32'h1);
      checkOutput("rst_busy", {31'h0, BUSY}, 32'h0);
      checkOutput("rst_done", {31'h0, DONE}, 32'h0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      // Frame S0F7 with BUSY length and single DONE
      doneBase = doneCount;
      applyStimulus(12'h0F7);
      checkOutput("t1_busy_k1", {31'h0, BUSY}, 32'h1);
      checkOutput("t1_tx_k1", {31'h0, TX}, 32'h0);
      receiveFrame(frame, ok);
      checkOutput("t1_rx_ok", {31'h0, ok}, 32'h1);
      checkOutput("t1_frame", frame, "S0F7");
      waitDone(found);
      checkOutput("t1_done_seen", {31'h0, found}, 32'h1);
      checkOutput("t1_busy_in_done", {31'h0, BUSY}, 32'h0);
      checkOutput("t1_tx_in_done", {31'h0, TX}, 32'h1);
      @(negedge CLK);
      checkOutput("t1_done_width", {31'h0, DONE}, 32'h0);
      checkOutput("t1_busy_len", lastBusyRun, 40 * CPB);
      checkOutput("t1_done_count", doneCount - doneBase, 32'd1);

      // Hex digit boundaries
      for (int v = 0; v < 4; v++) begin
         repeat (5) @(negedge CLK);
         applyStimulus(vecData[v]);
         receiveFrame(frame, ok);
         checkOutput("t2_rx_ok", {31'h0, ok}, 32'h1);
         checkOutput("t2_frame", frame, vecFrame[v]);
         waitDone(found);
         checkOutput("t2_done_seen", {31'h0, found}, 32'h1);
      end

      // START while busy is ignored
      repeat (5) @(negedge CLK);
      doneBase = doneCount;
      applyStimulus(12'h0F7);
      fork
         receiveFrame(frame, ok);
         begin
            repeat (498) @(negedge CLK);
            START = 1'b1;
            DATA  = 12'h123;
            @(negedge CLK);
            START = 1'b0;
         end
      join
      checkOutput("t3_rx_ok", {31'h0, ok}, 32'h1);
      checkOutput("t3_frame", frame, "S0F7");
      waitDone(found);
      checkOutput("t3_done_seen", {31'h0, found}, 32'h1);
      repeat (300) @(negedge CLK);
      checkOutput("t3_done_count", doneCount - doneBase, 32'd1);
      checkOutput("t3_idle_busy", {31'h0, BUSY}, 32'h0);

      // START held through DONE: back-to-back frames
      applyStimulus(12'h259);
      fork
         receiveFrame(frame, ok);
         begin
            repeat (4000) @(negedge CLK);
            START = 1'b1;
            DATA  = 12'h314;
         end
      join
      checkOutput("t4_first_frame", frame, "S259");
      waitDone(found);
      checkOutput("t4_done_seen", {31'h0, found}, 32'h1);
      checkOutput("t4_gap_tx", {31'h0, TX}, 32'h1);
      @(negedge CLK);
      START = 1'b0;
      checkOutput("t4_next_start_tx", {31'h0, TX}, 32'h0);
      checkOutput("t4_next_busy", {31'h0, BUSY}, 32'h1);
      receiveFrame(frame, ok);
      checkOutput("t4_rx_ok", {31'h0, ok}, 32'h1);
      checkOutput("t4_second_frame", frame, "S314");
      waitDone(found);
      checkOutput("t4_done2_seen", {31'h0, found}, 32'h1);
      checkOutput("t4_busy_len", lastBusyRun, 40 * CPB);

      // Asynchronous reset mid-frame
      repeat (5) @(negedge CLK);
      applyStimulus(12'h0F7);
      repeat (2300) @(negedge CLK);
      doneBase = doneCount;
      RST = 1'b1;
      #1;
      checkOutput("t5_async_tx", {31'h0, TX}, 32'h1);
      checkOutput("t5_async_busy", {31'h0, BUSY}, 32'h0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      repeat (300) @(negedge CLK);
      checkOutput("t5_no_done", doneCount - doneBase, 32'd0);
      checkOutput("t5_idle_tx", {31'h0, TX}, 32'h1);
      applyStimulus(12'h350);
      receiveFrame(frame, ok);
      checkOutput("t5_rx_ok", {31'h0, ok}, 32'h1);
      checkOutput("t5_frame", frame, "S350");
      waitDone(found);
      checkOutput("t5_done_seen", {31'h0, found}, 32'h1);

      // Long idle after reset
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      idleBad  = 1'b0;
      doneBase = doneCount;
      for (int i = 0; i < 10000; i++) begin
         @(negedge CLK);
         if (TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) idleBad = 1'b1;
      end
      checkOutput("t6_idle_stable", {31'h0, idleBad}, 32'h0);
      checkOutput("t6_no_done", doneCount - doneBase, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
